// File: rtl/stp_fsm_3_if.sv
// Bus bundle for the polynomial store engine: command inputs, command-buffer read port,
// S/N memory write ports and completion/status.
interface stp_fsm_3_if #(
  parameter int AW = 10
);
  logic          start_stp;
  logic [2:0]    A;
  logic [4:0]    N_in;
  logic [AW-1:0] rd_addr_cmd;
  logic [15:0]   ram_out_cmd;
  logic          en_rd_cmd;
  logic [AW-1:0] rd_addr_cmd_updated;
  logic          en_wr_S;
  logic [6:0]    wr_addr_S;
  logic [15:0]   wr_data_S;
  logic          en_wr_N;
  logic [2:0]    wr_addr_N;
  logic [4:0]    wr_data_N;
  logic          done_stp;
  logic [31:0]   status;

  modport master (
    output start_stp, A, N_in, rd_addr_cmd, ram_out_cmd,
    input  en_rd_cmd, rd_addr_cmd_updated, en_wr_S, wr_addr_S, wr_data_S,
           en_wr_N, wr_addr_N, wr_data_N, done_stp, status
  );

  modport slave (
    input  start_stp, A, N_in, rd_addr_cmd, ram_out_cmd,
    output en_rd_cmd, rd_addr_cmd_updated, en_wr_S, wr_addr_S, wr_data_S,
           en_wr_N, wr_addr_N, wr_data_N, done_stp, status
  );
endinterface

// File: rtl/stp_fsm_3.sv
// Polynomial store engine: copies N+1 coefficient tokens into S at A*11+i, then commits N.
// Optional macro STP_CLEAR_TAIL_EN zero-fills the unused coefficient slots above N.
module stp_fsm_3 #(
  parameter int buffer_size = 1024,
  parameter int AW          = $clog2(buffer_size)
) (
  input  logic        clk,
  input  logic        rst,
  stp_fsm_3_if.slave  bus
);

  localparam logic [31:0] ST_OK    = 32'h0000_0000;
  localparam logic [31:0] ST_DEGER = 32'h0000_0002;
  localparam logic [31:0] ST_BUSY  = 32'hFFFF_FFFF;
  localparam logic [4:0]  N_INVAL  = 5'b11111;
  localparam logic [4:0]  N_MAX    = 5'd10;
  localparam logic [3:0]  IDX_MAX  = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_INVAL    = 4'd2,
    S_CHECK_N  = 4'd3,
    S_RD_COEFF = 4'd4,
    S_WR_COEFF = 4'd5,
    S_WR_N     = 4'd6,
    S_ERROR    = 4'd7,
    S_END      = 4'd8
`ifdef STP_CLEAR_TAIL_EN
    , S_CLEAR  = 4'd9
`endif
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_a;
  logic [4:0]    r_n;
  logic [3:0]    r_idx;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_status;

  logic [3:0]    w_idx_inc;
  logic          w_last_coeff;
  logic          w_en_rd;
  logic          w_en_wr_S;
  logic [15:0]   w_wr_data_S;
  logic          w_en_wr_N;
  logic [4:0]    w_wr_data_N;
  logic          w_done;

  // Read address advance with explicit wrap for non-power-of-two depths.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (a == AW'(buffer_size - 1)) begin
      return {AW{1'b0}};
    end else begin
      return a + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_idx_inc    = r_idx + 4'd1;
  assign w_last_coeff = ({1'b0, w_idx_inc} > r_n);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_stp) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START:   w_state_nxt = S_INVAL;
      S_INVAL:   w_state_nxt = S_CHECK_N;
      S_CHECK_N: begin
        // 5'b11111 is above N_MAX as well, so the invalid marker lands in ERROR too.
        if (r_n > N_MAX) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_state_nxt = S_RD_COEFF;
        end
      end
      S_RD_COEFF: w_state_nxt = S_WR_COEFF;
      S_WR_COEFF: begin
        if (w_last_coeff) begin
`ifdef STP_CLEAR_TAIL_EN
          if (w_idx_inc > IDX_MAX) begin
            w_state_nxt = S_WR_N;
          end else begin
            w_state_nxt = S_CLEAR;
          end
`else
          w_state_nxt = S_WR_N;
`endif
        end else begin
          w_state_nxt = S_RD_COEFF;
        end
      end
`ifdef STP_CLEAR_TAIL_EN
      S_CLEAR: begin
        if (w_idx_inc > IDX_MAX) begin
          w_state_nxt = S_WR_N;
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
`endif
      S_WR_N:  w_state_nxt = S_END;
      S_ERROR: w_state_nxt = S_END;
      S_END:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, coefficient index, read pointer and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= 3'd0;
      r_n      <= 5'd0;
      r_idx    <= 4'd0;
      r_addr   <= {AW{1'b0}};
      r_status <= ST_BUSY;
    end else begin
      case (r_state)
        S_START: begin
          r_a      <= bus.A;
          r_n      <= bus.N_in;
          r_addr   <= bus.rd_addr_cmd;
          r_idx    <= 4'd0;
          r_status <= ST_BUSY;
        end
        S_WR_COEFF: begin
          r_idx  <= w_idx_inc;
          r_addr <= addr_inc(r_addr);
        end
`ifdef STP_CLEAR_TAIL_EN
        S_CLEAR: begin
          r_idx <= w_idx_inc;
        end
`endif
        S_WR_N:  r_status <= ST_OK;
        S_ERROR: r_status <= ST_DEGER;
        default: r_status <= r_status;
      endcase
    end
  end

  // Output decode from state.
  always_comb begin
    w_en_rd     = 1'b0;
    w_en_wr_S   = 1'b0;
    w_wr_data_S = 16'h0000;
    w_en_wr_N   = 1'b0;
    w_wr_data_N = 5'd0;
    w_done      = 1'b0;
    case (r_state)
      S_INVAL: begin
        w_en_wr_N   = 1'b1;
        w_wr_data_N = N_INVAL;
      end
      S_RD_COEFF: w_en_rd = 1'b1;
      S_WR_COEFF: begin
        w_en_wr_S   = 1'b1;
        w_wr_data_S = bus.ram_out_cmd;
      end
`ifdef STP_CLEAR_TAIL_EN
      S_CLEAR: begin
        w_en_wr_S   = 1'b1;
        w_wr_data_S = 16'h0000;
      end
`endif
      S_WR_N: begin
        w_en_wr_N   = 1'b1;
        w_wr_data_N = r_n;
      end
      S_END:   w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  assign bus.en_rd_cmd           = w_en_rd;
  assign bus.rd_addr_cmd_updated = r_addr;
  assign bus.en_wr_S             = w_en_wr_S;
  // Max 7*11+10 = 87, fits the 7-bit product.
  assign bus.wr_addr_S           = ({4'b0000, r_a} * 7'd11) + {3'b000, r_idx};
  assign bus.wr_data_S           = w_wr_data_S;
  assign bus.en_wr_N             = w_en_wr_N;
  assign bus.wr_addr_N           = r_a;
  assign bus.wr_data_N           = w_wr_data_N;
  assign bus.done_stp            = w_done;
  assign bus.status              = r_status;

endmodule
